// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execution-unit command sequencer:
// opcode values, instruction field positions and FSM state encoding.
package exec_sequencer_pkg;

  localparam int INSTR_W = 34;

  localparam logic [2:0] OP_WR     = 3'b000;
  localparam logic [2:0] OP_RD1    = 3'b001;
  localparam logic [2:0] OP_RD2    = 3'b010;
  localparam logic [2:0] OP_WR_RD1 = 3'b011;
  localparam logic [2:0] OP_WR_RD2 = 3'b100;
  localparam logic [2:0] OP_ADD    = 3'b101;
  localparam logic [2:0] OP_SUB    = 3'b110;
  localparam logic [2:0] OP_SHIFT  = 3'b111;

  localparam int OP_HI   = 33;
  localparam int OP_LO   = 31;
  localparam int RA1_HI  = 30;
  localparam int RA1_LO  = 26;
  localparam int RA2_HI  = 25;
  localparam int RA2_LO  = 21;
  localparam int WA_HI   = 20;
  localparam int WA_LO   = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FIN     = 3'd4
  } state_t;

  // Only plain register writes complete without returning data.
  function automatic logic has_result(input logic [2:0] op);
    return op != OP_WR;
  endfunction

endpackage

// File: rtl/exec_sequencer_instr.sv
// Instruction store: DEPTH x INSTR_W register array with one synchronous
// write port and one combinational read port. Contents are not reset.
module exec_instr_buffer
  import exec_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/exec_sequencer.sv
// Command sequencer: replays a preloaded instruction list to the execution
// unit one at a time, waiting for a rising edge of exe_done per instruction.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_valid,
  input  logic [AW-1:0]      ld_addr,
  input  logic [INSTR_W-1:0] ld_instr,
  input  logic               start,
  input  logic [AW:0]        prog_len,
  output logic               busy,
  output logic               finished,
  output logic               err,
  output logic [AW-1:0]      pc,
  output logic [2:0]         exe_valid,
  output logic [4:0]         exe_rd_adr1,
  output logic [4:0]         exe_rd_adr2,
  output logic [4:0]         exe_wr_adr,
  output logic [15:0]        exe_data,
  output logic               cmd_strobe,
  input  logic               exe_done,
  input  logic [15:0]        exe_rd1,
  input  logic [15:0]        exe_rd2,
  output logic               res_valid,
  output logic [AW-1:0]      res_pc,
  output logic [15:0]        res_rd1,
  output logic [15:0]        res_rd2
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state_reg, state_next;
  logic [AW:0]        len_reg;
  logic [TW-1:0]      tcnt_reg;
  logic               done_q;
  logic [INSTR_W-1:0] exe_hold_reg;
  logic [INSTR_W-1:0] cur_instr;
  logic [INSTR_W-1:0] exe_word;
  logic [AW:0]        eff_len;
  logic               done_edge;
  logic               last_instr;
  logic               wait_expired;

  exec_instr_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (ld_valid && state_reg == ST_IDLE),
    .waddr (ld_addr),
    .wdata (ld_instr),
    .raddr (pc),
    .rdata (cur_instr)
  );

  assign eff_len      = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  assign done_edge    = exe_done & ~done_q;
  assign last_instr   = ({1'b0, pc} == len_reg - 1'b1);
  assign wait_expired = (tcnt_reg == TW'(TIMEOUT - 1));

  // Fields come straight from the buffer during ISSUE and are then frozen
  // in the hold register until the next ISSUE.
  assign exe_word    = (state_reg == ST_ISSUE) ? cur_instr : exe_hold_reg;
  assign exe_valid   = exe_word[OP_HI:OP_LO];
  assign exe_rd_adr1 = exe_word[RA1_HI:RA1_LO];
  assign exe_rd_adr2 = exe_word[RA2_HI:RA2_LO];
  assign exe_wr_adr  = exe_word[WA_HI:WA_LO];
  assign exe_data    = exe_word[DATA_HI:DATA_LO];

  assign cmd_strobe = (state_reg == ST_ISSUE);
  assign finished   = (state_reg == ST_FIN);
  assign busy       = (state_reg != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = (eff_len == '0) ? ST_FIN : ST_ISSUE;
      ST_ISSUE:   state_next = ST_WAIT;
      ST_WAIT: begin
        if (done_edge)         state_next = ST_CAPTURE;
        else if (wait_expired) state_next = ST_IDLE;
      end
      ST_CAPTURE: state_next = last_instr ? ST_FIN : ST_ISSUE;
      ST_FIN:     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg      <= '0;
      tcnt_reg     <= '0;
      done_q       <= 1'b0;
      exe_hold_reg <= '0;
      err          <= 1'b0;
      pc           <= '0;
      res_valid    <= 1'b0;
      res_pc       <= '0;
      res_rd1      <= '0;
      res_rd2      <= '0;
    end else begin
      done_q    <= exe_done;
      res_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            len_reg <= eff_len;
            err     <= 1'b0;
            pc      <= '0;
          end
        end
        ST_ISSUE: begin
          exe_hold_reg <= cur_instr;
          tcnt_reg     <= '0;
        end
        ST_WAIT: begin
          tcnt_reg <= tcnt_reg + 1'b1;
          if (!done_edge && wait_expired) err <= 1'b1;
        end
        ST_CAPTURE: begin
          if (has_result(exe_hold_reg[OP_HI:OP_LO])) begin
            res_valid <= 1'b1;
            res_pc    <= pc;
            res_rd1   <= exe_rd1;
            res_rd2   <= exe_rd2;
          end
          if (!last_instr) pc <= pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
